// File: rtl/alu_cmd_ctrl.sv
// Command controller: parses 0xCC/0xDD frames from the RX byte stream, drives the ALU
// operand/function registers, fires one ALU enable and returns the 16-bit result as two TX bytes.
module alu_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_rx_p_data,
  input  logic                  i_rx_d_vld,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [3:0]            o_alu_fun,
  output logic                  o_alu_en,
  input  logic [OUT_WIDTH-1:0]  i_alu_out,
  input  logic                  i_alu_out_vld,
  output logic [DATA_WIDTH-1:0] o_tx_p_data,
  output logic                  o_tx_d_vld,
  input  logic                  i_tx_busy,
  output logic                  o_cmd_err
);

  localparam logic [DATA_WIDTH-1:0] CMD_FULL  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_REUSE = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WAIT_A   = 4'd1,
    S_WAIT_B   = 4'd2,
    S_WAIT_FUN = 4'd3,
    S_ALU_RUN  = 4'd4,
    S_WAIT_RES = 4'd5,
    S_SEND_LO  = 4'd6,
    S_GAP      = 4'd7,
    S_SEND_HI  = 4'd8
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [DATA_WIDTH-1:0]   r_alu_a;
  logic [DATA_WIDTH-1:0]   r_alu_b;
  logic [3:0]              r_alu_fun;
  logic [OUT_WIDTH-1:0]    r_result;
  logic                    r_cmd_err;
  logic                    w_load_a;
  logic                    w_load_b;
  logic                    w_load_fun;
  logic                    w_capture;
  logic                    w_cmd_err;
  logic                    w_alu_en;
  logic                    w_tx_vld;
  logic [DATA_WIDTH-1:0]   w_tx_data;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus strobes derived from the registered state
  always_comb begin
    w_next_state = r_state;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_load_fun   = 1'b0;
    w_capture    = 1'b0;
    w_cmd_err    = 1'b0;
    w_alu_en     = 1'b0;
    w_tx_vld     = 1'b0;
    w_tx_data    = '0;
    case (r_state)
      S_IDLE: begin
        if (i_rx_d_vld) begin
          if (i_rx_p_data == CMD_FULL) begin
            w_next_state = S_WAIT_A;
          end else if (i_rx_p_data == CMD_REUSE) begin
            w_next_state = S_WAIT_FUN;
          end else begin
            w_cmd_err = 1'b1;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WAIT_A: begin
        if (i_rx_d_vld) begin
          w_load_a     = 1'b1;
          w_next_state = S_WAIT_B;
        end else begin
          w_next_state = S_WAIT_A;
        end
      end
      S_WAIT_B: begin
        if (i_rx_d_vld) begin
          w_load_b     = 1'b1;
          w_next_state = S_WAIT_FUN;
        end else begin
          w_next_state = S_WAIT_B;
        end
      end
      S_WAIT_FUN: begin
        if (i_rx_d_vld) begin
          w_load_fun   = 1'b1;
          w_next_state = S_ALU_RUN;
        end else begin
          w_next_state = S_WAIT_FUN;
        end
      end
      S_ALU_RUN: begin
        w_alu_en     = 1'b1;
        w_cmd_err    = i_rx_d_vld;
        w_next_state = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        w_cmd_err = i_rx_d_vld;
        if (i_alu_out_vld) begin
          w_capture    = 1'b1;
          w_next_state = S_SEND_LO;
        end else begin
          w_next_state = S_WAIT_RES;
        end
      end
      S_SEND_LO: begin
        w_cmd_err = i_rx_d_vld;
        w_tx_data = r_result[DATA_WIDTH-1:0];
        if (!i_tx_busy) begin
          w_tx_vld     = 1'b1;
          w_next_state = S_GAP;
        end else begin
          w_next_state = S_SEND_LO;
        end
      end
      // Serializer busy may not have risen yet, so this cycle never looks at it
      S_GAP: begin
        w_cmd_err    = i_rx_d_vld;
        w_next_state = S_SEND_HI;
      end
      S_SEND_HI: begin
        w_cmd_err = i_rx_d_vld;
        w_tx_data = r_result[OUT_WIDTH-1:DATA_WIDTH];
        if (!i_tx_busy) begin
          w_tx_vld     = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_SEND_HI;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Operand, function and result registers; they hold until a new frame or reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_fun <= 4'd0;
      r_result  <= '0;
    end else begin
      if (w_load_a) begin
        r_alu_a <= i_rx_p_data;
      end
      if (w_load_b) begin
        r_alu_b <= i_rx_p_data;
      end
      if (w_load_fun) begin
        r_alu_fun <= i_rx_p_data[3:0];
      end
      if (w_capture) begin
        r_result <= i_alu_out;
      end
    end
  end

  // Error pulse lands in the cycle after the offending strobe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= w_cmd_err;
    end
  end

  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_fun   = r_alu_fun;
  assign o_alu_en    = w_alu_en;
  assign o_tx_p_data = w_tx_data;
  assign o_tx_d_vld  = w_tx_vld;
  assign o_cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Randomized self-checking bench for alu_cmd_ctrl with an ALU emulator, a serializer busy model
// and a frame-level reference model.
module tb_alu_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_vld = 1'b0;
  logic [7:0]  alu_a, alu_b, tx_data;
  logic [3:0]  alu_fun;
  logic        alu_en, tx_vld, cmd_err;
  logic [15:0] alu_out = 16'h0000;
  logic        alu_vld = 1'b0;
  logic        force_busy = 1'b0;
  logic        ser_busy = 1'b0;
  logic        tx_busy;

  assign tx_busy = force_busy | ser_busy;

  alu_cmd_ctrl #(.DATA_WIDTH(8), .OUT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_p_data(rx_data), .i_rx_d_vld(rx_vld),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_fun(alu_fun), .o_alu_en(alu_en),
    .i_alu_out(alu_out), .i_alu_out_vld(alu_vld),
    .o_tx_p_data(tx_data), .o_tx_d_vld(tx_vld), .i_tx_busy(tx_busy), .o_cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int en_cnt = 0, err_cnt = 0, en_cyc = -1, err_cyc = -1;
  int cmd_cyc = 0, fun_cyc = 0, last_rx_cyc = 0;
  int ser_len = 0, ser_cnt = 0;
  bit alu_pend = 1'b0, tx_pend = 1'b0;
  logic [7:0] txq[$];
  int         txc[$];
  logic [7:0] m_a = 8'h00, m_b = 8'h00;
  logic [3:0] m_fun = 4'h0;

  // Behavioural ALU used both to emulate the real ALU and to predict the returned bytes
  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    logic [15:0] wa, wb;
    wa = {8'h00, a};
    wb = {8'h00, b};
    case (f)
      4'd0:    return wa + wb;
      4'd1:    return wa - wb;
      4'd2:    return wa * wb;
      4'd3:    return {8'h00, a & b};
      default: return {a ^ {4'h0, f}, b ^ 8'h5A};
    endcase
  endfunction

  function automatic logic [15:0] model_frame(input logic [7:0] cmd, input logic [7:0] a,
                                              input logic [7:0] b, input logic [7:0] fun);
    if (cmd == 8'hCC) begin
      m_a = a;
      m_b = b;
    end
    m_fun = fun[3:0];
    return alu_f(m_a, m_b, m_fun);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (alu_en) begin en_cnt++; en_cyc = cyc; end
    if (cmd_err) begin err_cnt++; err_cyc = cyc; end
    if (tx_vld) begin txq.push_back(tx_data); txc.push_back(cyc); tx_pend = 1'b1; end
    alu_pend = alu_en;
  end

  // ALU emulator: result valid the cycle after the enable, garbage otherwise
  initial forever begin
    @(posedge clk);
    #1;
    if (alu_pend) begin
      alu_vld = 1'b1;
      alu_out = alu_f(alu_a, alu_b, alu_fun);
    end else begin
      alu_vld = 1'b0;
      alu_out = 16'($urandom);
    end
  end

  // Serializer: busy for ser_len cycles starting the cycle after each byte strobe
  initial forever begin
    @(posedge clk);
    #1;
    if (tx_pend) begin tx_pend = 1'b0; ser_cnt = ser_len; end
    if (ser_cnt > 0) begin ser_busy = 1'b1; ser_cnt--; end
    else ser_busy = 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_vld = 1'b1;
    last_rx_cyc = cyc;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_vld = 1'b0;
      rx_data = 8'($urandom);
    end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] fun, input int gap);
    send_byte(cmd);
    cmd_cyc = last_rx_cyc;
    if (cmd == 8'hCC) begin
      idle_cycles(gap);
      send_byte(a);
      idle_cycles(gap);
      send_byte(b);
    end
    idle_cycles(gap);
    send_byte(fun);
    fun_cyc = last_rx_cyc;
    idle_cycles(1);
  endtask

  task automatic wait_tx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (txq.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({alu_a, alu_b, alu_fun, alu_en, tx_data, tx_vld, cmd_err} !== 30'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", {alu_a, alu_b, alu_fun, alu_en, tx_data, tx_vld, cmd_err});
    end
    rst_n = 1'b1;
    m_a = 8'h00; m_b = 8'h00; m_fun = 4'h0;
    idle_cycles(2);
  endtask

  task automatic test_cc_frame;
    int e0;
    bit ok;
    logic [15:0] exp;
    ser_len = 0;
    txq.delete(); txc.delete();
    e0 = en_cnt;
    exp = model_frame(8'hCC, 8'h05, 8'h03, 8'h00);
    send_frame(8'hCC, 8'h05, 8'h03, 8'h00, 0);
    wait_tx(2, 40, ok);
    idle_cycles(5);
    tests_run++;
    if (!ok || txq.size() != 2) begin
      tests_failed++;
      $display("FAIL cc_tx_count: got %0d expected 2", txq.size());
    end else begin
      tests_run++;
      if (txq[0] !== 8'h08 || txq[1] !== 8'h00 || exp !== 16'h0008) begin
        tests_failed++;
        $display("FAIL cc_bytes: got %h %h expected 08 00", txq[0], txq[1]);
      end
      tests_run++;
      if (txc[0] != fun_cyc + 3 || txc[1] != txc[0] + 2) begin
        tests_failed++;
        $display("FAIL cc_tx_timing: got %0d %0d expected %0d %0d", txc[0], txc[1], fun_cyc + 3, fun_cyc + 5);
      end
    end
    tests_run++;
    if (en_cnt - e0 != 1 || en_cyc != cmd_cyc + 4) begin
      tests_failed++;
      $display("FAIL cc_alu_en: got count %0d at %0d expected 1 at %0d", en_cnt - e0, en_cyc, cmd_cyc + 4);
    end
    tests_run++;
    if (alu_a !== 8'h05 || alu_b !== 8'h03 || alu_fun !== 4'h0) begin
      tests_failed++;
      $display("FAIL cc_operands: got %h %h %h expected 05 03 0", alu_a, alu_b, alu_fun);
    end
  endtask

  task automatic test_mul_then_reuse;
    bit ok;
    logic [15:0] exp;
    ser_len = 1;
    txq.delete(); txc.delete();
    exp = model_frame(8'hCC, 8'h10, 8'h10, 8'h02);
    send_frame(8'hCC, 8'h10, 8'h10, 8'h02, 0);
    wait_tx(2, 40, ok);
    tests_run++;
    if (!ok || txq[0] !== 8'h00 || txq[1] !== 8'h01 || exp !== 16'h0100) begin
      tests_failed++;
      $display("FAIL mul_bytes: got ok=%0d %h %h expected 00 01", ok, txq[0], txq[1]);
    end
    txq.delete(); txc.delete();
    exp = model_frame(8'hDD, 8'h00, 8'h00, 8'h01);
    send_frame(8'hDD, 8'h00, 8'h00, 8'h01, 0);
    wait_tx(2, 40, ok);
    tests_run++;
    if (alu_a !== 8'h10 || alu_b !== 8'h10 || alu_fun !== 4'h1) begin
      tests_failed++;
      $display("FAIL reuse_operands: got %h %h %h expected 10 10 1", alu_a, alu_b, alu_fun);
    end
    tests_run++;
    if (!ok || txq[0] !== exp[7:0] || txq[1] !== exp[15:8]) begin
      tests_failed++;
      $display("FAIL reuse_bytes: got ok=%0d %h %h expected %h %h", ok, txq[0], txq[1], exp[7:0], exp[15:8]);
    end
  endtask

  task automatic test_bad_cmd;
    int e0, r0;
    bit ok;
    logic [15:0] exp;
    txq.delete(); txc.delete();
    e0 = en_cnt; r0 = err_cnt;
    send_byte(8'h55);
    idle_cycles(6);
    tests_run++;
    if (err_cnt - r0 != 1 || err_cyc != last_rx_cyc + 1) begin
      tests_failed++;
      $display("FAIL bad_cmd_err: got %0d pulses at %0d expected 1 at %0d", err_cnt - r0, err_cyc, last_rx_cyc + 1);
    end
    tests_run++;
    if (en_cnt != e0 || txq.size() != 0 || tx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL bad_cmd_quiet: got en %0d tx %0d data %h expected 0 0 00", en_cnt - e0, txq.size(), tx_data);
    end
    exp = model_frame(8'hCC, 8'hA7, 8'h3C, 8'h01);
    send_frame(8'hCC, 8'hA7, 8'h3C, 8'h01, 0);
    wait_tx(2, 40, ok);
    tests_run++;
    if (!ok || en_cnt - e0 != 1 || txq[0] !== exp[7:0] || txq[1] !== exp[15:8]) begin
      tests_failed++;
      $display("FAIL bad_cmd_recover: got ok=%0d en %0d %h %h expected %h %h", ok, en_cnt - e0, txq[0], txq[1], exp[7:0], exp[15:8]);
    end
  endtask

  task automatic test_busy_stall;
    bit ok;
    int rel;
    logic [15:0] exp;
    ser_len = 0;
    txq.delete(); txc.delete();
    @(posedge clk); #1; force_busy = 1'b1;
    exp = model_frame(8'hCC, 8'($urandom), 8'($urandom), 8'h01);
    send_frame(8'hCC, m_a, m_b, 8'h01, 0);
    while (cyc < fun_cyc + 13) begin @(posedge clk); #1; end
    force_busy = 1'b0;
    rel = cyc;
    tests_run++;
    if (txq.size() != 0) begin
      tests_failed++;
      $display("FAIL busy_stall_quiet: got %0d bytes expected 0", txq.size());
    end
    wait_tx(2, 40, ok);
    tests_run++;
    if (!ok || txc[0] != rel || txc[1] != rel + 2) begin
      tests_failed++;
      $display("FAIL busy_release_timing: got ok=%0d %0d %0d expected %0d %0d", ok, txc[0], txc[1], rel, rel + 2);
    end
    tests_run++;
    if (!ok || txq[0] !== exp[7:0] || txq[1] !== exp[15:8]) begin
      tests_failed++;
      $display("FAIL busy_bytes: got %h %h expected %h %h", txq[0], txq[1], exp[7:0], exp[15:8]);
    end
  endtask

  task automatic test_drop_in_send;
    bit ok;
    int e0, r0, lo;
    logic [15:0] exp;
    ser_len = 4;
    txq.delete(); txc.delete();
    e0 = en_cnt; r0 = err_cnt;
    exp = model_frame(8'hCC, 8'h9E, 8'h21, 8'h02);
    send_frame(8'hCC, 8'h9E, 8'h21, 8'h02, 0);
    wait_tx(1, 40, ok);
    lo = ok ? txc[0] : 0;
    send_byte(8'hAA);
    send_byte(8'hAA);
    idle_cycles(1);
    wait_tx(2, 40, ok);
    tests_run++;
    if (err_cnt - r0 != 2 || err_cyc != lo + 3) begin
      tests_failed++;
      $display("FAIL drop_err: got %0d pulses last %0d expected 2 last %0d", err_cnt - r0, err_cyc, lo + 3);
    end
    tests_run++;
    if (!ok || txq[0] !== exp[7:0] || txq[1] !== exp[15:8] || txc[1] != lo + 5) begin
      tests_failed++;
      $display("FAIL drop_result: got %h %h at %0d expected %h %h at %0d", txq[0], txq[1], txc[1], exp[7:0], exp[15:8], lo + 5);
    end
    tests_run++;
    if (en_cnt - e0 != 1) begin
      tests_failed++;
      $display("FAIL drop_alu_en: got %0d expected 1", en_cnt - e0);
    end
    txq.delete(); txc.delete();
    exp = model_frame(8'hDD, 8'h00, 8'h00, 8'h00);
    send_frame(8'hDD, 8'h00, 8'h00, 8'h00, 0);
    wait_tx(2, 40, ok);
    tests_run++;
    if (!ok || txq[0] !== exp[7:0] || txq[1] !== exp[15:8]) begin
      tests_failed++;
      $display("FAIL drop_then_idle: got ok=%0d %h %h expected %h %h", ok, txq[0], txq[1], exp[7:0], exp[15:8]);
    end
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    logic [15:0] exp;
    ser_len = 0;
    send_byte(8'hCC);
    send_byte(8'h07);
    idle_cycles(1);
    tests_run++;
    if (alu_a !== 8'h07) begin
      tests_failed++;
      $display("FAIL mid_frame_a: got %h expected 07", alu_a);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({alu_a, alu_b, alu_fun, alu_en, tx_data, tx_vld, cmd_err} !== 30'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got %h expected 0", {alu_a, alu_b, alu_fun, alu_en, tx_data, tx_vld, cmd_err});
    end
    idle_cycles(2);
    rst_n = 1'b1;
    m_a = 8'h00; m_b = 8'h00; m_fun = 4'h0;
    idle_cycles(1);
    txq.delete(); txc.delete();
    exp = model_frame(8'hDD, 8'h00, 8'h00, 8'h00);
    send_frame(8'hDD, 8'h00, 8'h00, 8'h00, 0);
    wait_tx(2, 40, ok);
    tests_run++;
    if (!ok || alu_a !== 8'h00 || alu_b !== 8'h00 || txq[0] !== exp[7:0] || txq[1] !== exp[15:8]) begin
      tests_failed++;
      $display("FAIL post_reset_dd: got a=%h b=%h %h %h expected 00 00 00 00", alu_a, alu_b, txq[0], txq[1]);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int e0, gap, hi_exp;
    logic [7:0] cmd, a, b, fun;
    logic [15:0] exp;
    for (int it = 0; it < 24; it++) begin
      cmd = ($urandom_range(0, 2) != 0) ? 8'hCC : 8'hDD;
      a = 8'($urandom); b = 8'($urandom);
      fun = 8'($urandom_range(0, 7)) | (8'($urandom_range(0, 15)) << 4);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      ser_len = $urandom_range(0, 4);
      txq.delete(); txc.delete();
      e0 = en_cnt;
      exp = model_frame(cmd, a, b, fun);
      send_frame(cmd, a, b, fun, gap);
      wait_tx(2, 60, ok);
      hi_exp = (ser_len + 1 > 2) ? ser_len + 1 : 2;
      tests_run++;
      if (!ok || txq[0] !== exp[7:0] || txq[1] !== exp[15:8]) begin
        tests_failed++;
        $display("FAIL rand_bytes[%0d]: got ok=%0d %h %h expected %h %h", it, ok, txq[0], txq[1], exp[7:0], exp[15:8]);
      end
      tests_run++;
      if (!ok || txc[0] != fun_cyc + 3 || txc[1] != txc[0] + hi_exp) begin
        tests_failed++;
        $display("FAIL rand_timing[%0d]: got %0d %0d expected %0d %0d", it, txc[0], txc[1], fun_cyc + 3, fun_cyc + 3 + hi_exp);
      end
      tests_run++;
      if (en_cnt - e0 != 1 || en_cyc != fun_cyc + 1 || alu_a !== m_a || alu_b !== m_b || alu_fun !== m_fun) begin
        tests_failed++;
        $display("FAIL rand_alu[%0d]: got en %0d@%0d %h %h %h expected 1@%0d %h %h %h", it, en_cnt - e0, en_cyc,
                 alu_a, alu_b, alu_fun, fun_cyc + 1, m_a, m_b, m_fun);
      end
      if (gap == 0 && cmd == 8'hCC) begin
        tests_run++;
        if (en_cyc != cmd_cyc + 4) begin
          tests_failed++;
          $display("FAIL rand_cc_latency[%0d]: got %0d expected %0d", it, en_cyc, cmd_cyc + 4);
        end
      end
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 4));
    end
  endtask

  initial begin
    test_reset();
    test_cc_frame();
    test_mul_then_reuse();
    test_bad_cmd();
    test_busy_stall();
    test_drop_in_send();
    test_reset_mid_frame();
    test_back_to_back();
    idle_cycles(3);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
